pll_hdmi_cfg_seq: RTL
=====================

Name: pll_hdmi_cfg_seq

Overview:
Parametrised reconfiguration sequencer for the fractional HDMI pixel/serial PLL. On request it programs N, M, fractional K and NUM_CLOCKS output C counters through an Avalon-MM master into the Altera PLL reconfig block. It then starts the reconfiguration and waits for stable lock, with a timeout and bounded retries. It sits between the video-mode control logic and the PLL reconfig IP, in the refclk (50 MHz management) domain.

Parameters:
NUM_CLOCKS, 2, number of C counters programmed, range 1..18; counter i is written with select index i.
LOCK_STABLE, 16, consecutive cycles locked must be high before done.
LOCK_TIMEOUT, 65535, cycles allowed from the end of START until stable lock; counter width is clog2(LOCK_TIMEOUT+1).
RETRIES, 2, extra full sequences attempted after a timeout before err is raised.

Ports:
refclk  in  1  management clock; all logic is clocked on its rising edge.
rst_n  in  1  synchronous active-low reset.
cfg_req  in  1  one-cycle start pulse; sampled only in IDLE.
cfg_n  in  18  N word: [7:0] lo, [15:8] hi, [16] bypass, [17] odd.
cfg_m  in  18  M word, same format as cfg_n.
cfg_k  in  32  fractional K value.
cfg_c  in  NUM_CLOCKS*18  C words; counter i occupies bits [18i+17:18i].
busy  out  1  high from the accepted cfg_req until DONE or ERR.
done  out  1  one-cycle pulse on successful lock.
err  out  1  sticky; cleared by the next accepted cfg_req or by reset.
mgmt_address  out  6  reconfig register address.
mgmt_write  out  1  write strobe.
mgmt_writedata  out  32  write data.
mgmt_waitrequest  in  1  slave stall.
pll_locked  in  1  PLL locked; synchronised internally with 2 flops.

Behaviour:
- Reset: all outputs are 0; state is IDLE; shadow registers are invalid.
- Reset asserted mid-sequence: mgmt_write drops on the next edge and no partial write is completed.
- In IDLE, cfg_req captures all cfg_* into holding registers, clears err, sets busy and goes to MODE. cfg_req while busy is ignored.
- States and write order: MODE writes addr 0 = 0 (waitrequest mode), then N writes addr 3 = cfg_n, then M writes addr 4 = cfg_m, then K writes addr 7 = cfg_k, then C writes addr 5 = {9'b0, i[4:0], cfg_c word i} for i = 0..NUM_CLOCKS-1 in order, then START writes addr 2 = 0, then LOCKWAIT, then DONE or ERR, then IDLE.
- Write handshake:
  - mgmt_write, mgmt_address and mgmt_writedata are registered and held stable while mgmt_waitrequest = 1.
  - A write completes on the first edge where mgmt_write = 1 and mgmt_waitrequest = 0.
  - The next write is issued no earlier than the following cycle, so mgmt_write always has at least one low cycle between writes.
- START: the reconfig IP holds waitrequest for the whole reconfiguration. The sequencer simply waits, with no timeout applied there.
- LOCKWAIT:
  - The timeout counter is cleared on entry and increments each cycle.
  - The stability counter increments while synchronised locked = 1 and clears to 0 whenever locked = 0.
  - Stability counter reaching LOCK_STABLE goes to DONE: done pulses for 1 cycle and busy falls in the same cycle.
  - Timeout counter reaching LOCK_TIMEOUT with retries remaining restarts at MODE using the held values; the retry counter decrements.
  - Timeout with no retries remaining goes to ERR: err = 1 and busy falls.
  - If both counters reach their limits in the same cycle, lock wins.
- Minimum latency, with waitrequest always 0 and LOCK_STABLE cycles of lock: 2*(5+NUM_CLOCKS) write cycles + 2 synchroniser cycles + LOCK_STABLE.

Optional Feature:
Macro PLL_HDMI_CFG_SKIP_EN.
- When defined: the block keeps a shadow copy of N, M, K and each C word that was last successfully written. A write whose value equals its valid shadow is skipped (that state advances in 1 cycle with no mgmt_write). MODE and START are never skipped. Shadows are updated on each completed write and invalidated by reset and on entry to ERR.
- When undefined: every register is written on every sequence, and no shadow logic exists.

Test Plan:
- NUM_CLOCKS=2, waitrequest=0, locked rises after START -> exactly 7 writes to addresses 0, 3, 4, 7, 5, 5, 2. The C data carries select 0 then 1. done pulses once, LOCK_STABLE+2 cycles after the locked edge.
- waitrequest held high for 5 cycles during the M write -> address and data are stable throughout; exactly one M write completes; the sequence then continues.
- locked never rises, RETRIES=2, LOCK_TIMEOUT=100 -> 3 complete write sequences, then err=1 and busy=0; the next cfg_req clears err.
- locked glitches low 1 cycle at stability count 10 -> the count restarts; done is delayed by 11 cycles.
- rst_n=0 during the K write -> the next cycle shows mgmt_write=0, busy=0, state IDLE; a new cfg_req runs the full sequence.
- With PLL_HDMI_CFG_SKIP_EN, two identical requests -> the second request produces only the MODE and START writes, and done still pulses.

Source files
------------

// File: rtl/pll_hdmi_cfg_seq.sv
// Reconfiguration sequencer for the fractional HDMI PLL: writes N/M/K/C through Avalon-MM, starts, waits for stable lock.
// Optional macro PLL_HDMI_CFG_SKIP_EN: skip N/M/K/C writes whose value matches the last successfully written shadow.
module pll_hdmi_cfg_seq #(
  parameter int NUM_CLOCKS   = 2,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RETRIES      = 2
) (
  input  logic                     refclk,
  input  logic                     rst_n,
  input  logic                     cfg_req,
  input  logic [17:0]              cfg_n,
  input  logic [17:0]              cfg_m,
  input  logic [31:0]              cfg_k,
  input  logic [NUM_CLOCKS*18-1:0] cfg_c,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [5:0]               mgmt_address,
  output logic                     mgmt_write,
  output logic [31:0]              mgmt_writedata,
  input  logic                     mgmt_waitrequest,
  input  logic                     pll_locked
);
  localparam int CIW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;
  localparam int TOW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW  = $clog2(LOCK_STABLE + 1);
  localparam int RW  = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [CIW-1:0] C_LAST = CIW'(NUM_CLOCKS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_MODE, S_N, S_M, S_K, S_C, S_START, S_LOCKWAIT, S_DONE, S_ERR
  } state_t;

  state_t                       state_q, state_d;
  logic [17:0]                  n_q, n_d, m_q, m_d;
  logic [31:0]                  k_q, k_d;
  logic [NUM_CLOCKS-1:0][17:0]  c_q, c_d;
  logic [CIW-1:0]               ci_q, ci_d;
  logic [RW-1:0]                retry_q, retry_d;
  logic [TOW-1:0]               to_q, to_d, to_nxt;
  logic [SW-1:0]                stab_q, stab_d, stab_nxt;
  logic                         sync1_q, sync2_q;
  logic                         busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                         wr_q, wr_d;
  logic [5:0]                   addr_q, addr_d;
  logic [31:0]                  wdata_q, wdata_d;

  logic                         is_wr_state, skip_hit, adv, wr_done, ent_err;
  logic [5:0]                   wa;
  logic [31:0]                  wd;

  // Register address and data targeted by the current write state.
  always_comb begin
    is_wr_state = 1'b1;
    wa          = 6'd0;
    wd          = 32'd0;
    case (state_q)
      S_MODE:  begin wa = 6'd0; wd = 32'd0;                        end
      S_N:     begin wa = 6'd3; wd = {14'd0, n_q};                 end
      S_M:     begin wa = 6'd4; wd = {14'd0, m_q};                 end
      S_K:     begin wa = 6'd7; wd = k_q;                          end
      S_C:     begin wa = 6'd5; wd = {9'd0, 5'(ci_q), c_q[ci_q]};  end
      S_START: begin wa = 6'd2; wd = 32'd0;                        end
      default: is_wr_state = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    m_d      = m_q;
    k_d      = k_q;
    c_d      = c_q;
    ci_d     = ci_q;
    retry_d  = retry_q;
    to_d     = to_q;
    stab_d   = stab_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    adv      = 1'b0;
    wr_done  = 1'b0;
    ent_err  = 1'b0;
    stab_nxt = sync2_q ? stab_q + 1'b1 : '0;
    to_nxt   = to_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cfg_req) begin
          n_d     = cfg_n;
          m_d     = cfg_m;
          k_d     = cfg_k;
          c_d     = cfg_c;
          ci_d    = '0;
          retry_d = RW'(RETRIES);
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_MODE;
        end
      end
      S_LOCKWAIT: begin
        stab_d = stab_nxt;
        to_d   = to_nxt;
        // Lock is tested first so it wins a same-cycle tie with the timeout.
        if (sync2_q && stab_nxt == SW'(LOCK_STABLE)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (to_nxt == TOW'(LOCK_TIMEOUT)) begin
          if (retry_q != '0) begin
            retry_d = retry_q - 1'b1;
            ci_d    = '0;
            state_d = S_MODE;
          end else begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            ent_err = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default: begin
        if (is_wr_state) begin
          if (wr_q) begin
            if (!mgmt_waitrequest) begin
              wr_d    = 1'b0;
              wr_done = 1'b1;
              adv     = 1'b1;
            end
          end else if (skip_hit) begin
            adv = 1'b1;
          end else begin
            wr_d    = 1'b1;
            addr_d  = wa;
            wdata_d = wd;
          end
        end
      end
    endcase

    // Advancing with wr_q cleared guarantees a low strobe cycle before the next write.
    if (adv) begin
      case (state_q)
        S_MODE: state_d = S_N;
        S_N:    state_d = S_M;
        S_M:    state_d = S_K;
        S_K:    state_d = S_C;
        S_C: begin
          if (ci_q == C_LAST) begin
            ci_d    = '0;
            state_d = S_START;
          end else begin
            ci_d = ci_q + 1'b1;
          end
        end
        S_START: begin
          to_d    = '0;
          stab_d  = '0;
          state_d = S_LOCKWAIT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      m_q     <= '0;
      k_q     <= '0;
      c_q     <= '0;
      ci_q    <= '0;
      retry_q <= '0;
      to_q    <= '0;
      stab_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      k_q     <= k_d;
      c_q     <= c_d;
      ci_q    <= ci_d;
      retry_q <= retry_d;
      to_q    <= to_d;
      stab_q  <= stab_d;
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef PLL_HDMI_CFG_SKIP_EN
  logic [17:0]                 sh_n_q, sh_n_d, sh_m_q, sh_m_d;
  logic [31:0]                 sh_k_q, sh_k_d;
  logic [NUM_CLOCKS-1:0][17:0] sh_c_q, sh_c_d;
  logic                        sh_n_v_q, sh_n_v_d, sh_m_v_q, sh_m_v_d, sh_k_v_q, sh_k_v_d;
  logic [NUM_CLOCKS-1:0]       sh_c_v_q, sh_c_v_d;

  always_comb begin
    skip_hit = 1'b0;
    case (state_q)
      S_N:     skip_hit = sh_n_v_q && (sh_n_q == n_q);
      S_M:     skip_hit = sh_m_v_q && (sh_m_q == m_q);
      S_K:     skip_hit = sh_k_v_q && (sh_k_q == k_q);
      S_C:     skip_hit = sh_c_v_q[ci_q] && (sh_c_q[ci_q] == c_q[ci_q]);
      default: skip_hit = 1'b0;
    endcase
  end

  always_comb begin
    sh_n_d   = sh_n_q;
    sh_m_d   = sh_m_q;
    sh_k_d   = sh_k_q;
    sh_c_d   = sh_c_q;
    sh_n_v_d = sh_n_v_q;
    sh_m_v_d = sh_m_v_q;
    sh_k_v_d = sh_k_v_q;
    sh_c_v_d = sh_c_v_q;
    if (wr_done) begin
      case (state_q)
        S_N: begin sh_n_d = n_q; sh_n_v_d = 1'b1; end
        S_M: begin sh_m_d = m_q; sh_m_v_d = 1'b1; end
        S_K: begin sh_k_d = k_q; sh_k_v_d = 1'b1; end
        S_C: begin sh_c_d[ci_q] = c_q[ci_q]; sh_c_v_d[ci_q] = 1'b1; end
        default: ;
      endcase
    end
    // A failed lock leaves the PLL contents unknown, so forget everything.
    if (ent_err) begin
      sh_n_v_d = 1'b0;
      sh_m_v_d = 1'b0;
      sh_k_v_d = 1'b0;
      sh_c_v_d = '0;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sh_n_q   <= '0;
      sh_m_q   <= '0;
      sh_k_q   <= '0;
      sh_c_q   <= '0;
      sh_n_v_q <= 1'b0;
      sh_m_v_q <= 1'b0;
      sh_k_v_q <= 1'b0;
      sh_c_v_q <= '0;
    end else begin
      sh_n_q   <= sh_n_d;
      sh_m_q   <= sh_m_d;
      sh_k_q   <= sh_k_d;
      sh_c_q   <= sh_c_d;
      sh_n_v_q <= sh_n_v_d;
      sh_m_v_q <= sh_m_v_d;
      sh_k_v_q <= sh_k_v_d;
      sh_c_v_q <= sh_c_v_d;
    end
  end
`else
  assign skip_hit = 1'b0;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign mgmt_write     = wr_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = wdata_q;
endmodule
